// File: rtl/oppm_rx.sv
// OPPM receiver: frames pulses into slot windows, decodes symbols, and
// delivers complete packets over a valid/ready handshake with error reporting.
module oppm_rx #(
    parameter int N_MOD  = 2,
    parameter int L      = 8,
    parameter int DELTA  = 1,
    parameter int PRE_CT = 2,
    parameter int N_SYM  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pulse,
    output logic [N_MOD*N_SYM-1:0] pkt_data,
    output logic                   pkt_valid,
    input  logic                   pkt_ready,
    output logic                   err_valid,
    output logic [2:0]             err_code,
    output logic                   overrun,
    output logic                   busy
);

    localparam int S   = (2**N_MOD) * L;
    localparam int TOT = PRE_CT + N_SYM;
    localparam int PW  = N_MOD * N_SYM;
    localparam int QW  = $clog2(S);
    localparam int WW  = $clog2(TOT + 1);

    // The framing edge itself sits at offset DELTA, so the first counted
    // cycle after it is DELTA+1.
    localparam logic [QW-1:0] Q_START = QW'(DELTA + 1);
    localparam logic [QW-1:0] Q_LAST  = QW'(S - 1);
    localparam logic [QW-1:0] L_Q     = QW'(L);
    localparam logic [QW-1:0] TOL     = QW'(2 * DELTA);
    localparam logic [WW-1:0] W_LAST  = WW'(TOT - 1);

    localparam logic [2:0] ERR_MISS     = 3'd1;
    localparam logic [2:0] ERR_MULTI    = 3'd2;
    localparam logic [2:0] ERR_JITTER   = 3'd3;
    localparam logic [2:0] ERR_PREAMBLE = 3'd4;

    // A tolerance window wider than the slot would let neighbouring slots overlap.
    if (2 * DELTA >= L) begin : g_bad_delta
        $error("oppm_rx: 2*DELTA must be smaller than L");
    end

    typedef enum logic {
        S_WAIT,
        S_FRAME
    } state_t;

    state_t          state_q, state_d;
    logic [QW-1:0]   q_q, q_d;          // offset inside current window
    logic [WW-1:0]   win_q, win_d;      // current window index
    logic            got_q, got_d;      // window already has its accepted edge
    logic [PW-1:0]   asm_q, asm_d;      // symbol assembly register
    logic            prev_q;            // pulse level in previous cycle
    logic [PW-1:0]   pkt_data_d;
    logic            pkt_valid_d;
    logic            err_valid_d;
    logic [2:0]      err_code_d;
    logic            overrun_d;

    logic            edge_det;
    logic [QW-1:0]   q_sub;
    logic [N_MOD-1:0] q_slot;
    logic            in_pre;
    logic            abort;
    logic [2:0]      abort_code;
    logic            acc;

    assign edge_det = pulse & ~prev_q;
    assign q_sub    = q_q % L_Q;
    assign q_slot   = N_MOD'(q_q / L_Q);
    assign in_pre   = (int'(win_q) < PRE_CT);
    assign busy     = (state_q == S_FRAME);

    // Next-state, window bookkeeping, decode and handshake logic.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d     = state_q;
        q_d         = q_q;
        win_d       = win_q;
        got_d       = got_q;
        asm_d       = asm_q;
        pkt_data_d  = pkt_data;
        pkt_valid_d = pkt_valid;
        err_valid_d = 1'b0;
        err_code_d  = err_code;
        overrun_d   = 1'b0;
        abort       = 1'b0;
        abort_code  = ERR_MISS;
        acc         = 1'b0;

        // Consumer handshake; a packet loading below overrides the clear.
        if (pkt_valid && pkt_ready) begin
            pkt_valid_d = 1'b0;
        end

        unique case (state_q)
            S_WAIT: begin
                // Edges in the abort-report cycle belong to no packet.
                if (edge_det && !err_valid) begin
                    // The framing edge is window 0's pulse in slot 0, which
                    // decodes to all-zero bits, so a cleared register is exact.
                    state_d = S_FRAME;
                    q_d     = Q_START;
                    win_d   = '0;
                    got_d   = 1'b1;
                    asm_d   = '0;
                end
            end

            S_FRAME: begin
                if (edge_det) begin
                    if (got_q) begin
                        abort      = 1'b1;
                        abort_code = ERR_MULTI;
                    end else if (q_sub > TOL) begin
                        abort      = 1'b1;
                        abort_code = ERR_JITTER;
                    end else if (in_pre && (q_slot != '0)) begin
                        abort      = 1'b1;
                        abort_code = ERR_PREAMBLE;
                    end else begin
                        acc   = 1'b1;
                        got_d = 1'b1;
                        if (!in_pre) begin
                            // Shifting in keeps the first data symbol in the MSBs.
                            asm_d = (asm_q << N_MOD) | PW'(q_slot);
                        end
                    end
                end

                if (!abort) begin
                    if (q_q == Q_LAST) begin
                        if (!(got_q || acc)) begin
                            abort      = 1'b1;
                            abort_code = ERR_MISS;
                        end else if (win_q == W_LAST) begin
                            state_d = S_WAIT;
                            if (!pkt_valid || pkt_ready) begin
                                pkt_data_d  = asm_d;
                                pkt_valid_d = 1'b1;
                            end else begin
                                overrun_d = 1'b1;
                            end
                        end else begin
                            win_d = win_q + WW'(1);
                            q_d   = '0;
                            got_d = 1'b0;
                        end
                    end else begin
                        q_d = q_q + QW'(1);
                    end
                end

                if (abort) begin
                    state_d     = S_WAIT;
                    err_valid_d = 1'b1;
                    err_code_d  = abort_code;
                end
            end

            default: state_d = S_WAIT;
        endcase
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state_q   <= S_WAIT;
            q_q       <= '0;
            win_q     <= '0;
            got_q     <= 1'b0;
            asm_q     <= '0;
            // A pulse held high through reset release must not look like an edge.
            prev_q    <= 1'b1;
            pkt_data  <= '0;
            pkt_valid <= 1'b0;
            err_valid <= 1'b0;
            err_code  <= '0;
            overrun   <= 1'b0;
        end else begin
            state_q   <= state_d;
            q_q       <= q_d;
            win_q     <= win_d;
            got_q     <= got_d;
            asm_q     <= asm_d;
            prev_q    <= pulse;
            pkt_data  <= pkt_data_d;
            pkt_valid <= pkt_valid_d;
            err_valid <= err_valid_d;
            err_code  <= err_code_d;
            overrun   <= overrun_d;
        end
    end

endmodule

// File: tb/tb_oppm_rx.sv
// Directed testbench for oppm_rx with default parameters (S = 32 cycles).
module tb_oppm_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pulse = 1'b0;
    logic [7:0] pkt_data;
    logic       pkt_valid;
    logic       pkt_ready = 1'b1;
    logic       err_valid;
    logic [2:0] err_code;
    logic       overrun;
    logic       busy;

    int tests_run = 0;
    int tests_failed = 0;

    // Observations collected by run_seq, cycle numbers relative to t0 = 0.
    int         err_cyc;
    int         err_cnt;
    logic [2:0] err_c;
    logic       busy_at_err;
    int         val_cyc;
    logic [7:0] val_data;
    int         ovr_cyc;
    int         ovr_cnt;
    logic       busy_at_1;

    oppm_rx dut (
        .clk       (clk),
        .rst       (rst),
        .pulse     (pulse),
        .pkt_data  (pkt_data),
        .pkt_valid (pkt_valid),
        .pkt_ready (pkt_ready),
        .err_valid (err_valid),
        .err_code  (err_code),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Drive one-cycle pulses at the listed cycles (-1 = unused) and log outputs.
    task automatic run_seq(input int ev[12], input int ncyc, input logic rdy);
        logic p;
        err_cyc = -1; err_cnt = 0; err_c = '0; busy_at_err = 1'b1;
        val_cyc = -1; val_data = '0; ovr_cyc = -1; ovr_cnt = 0; busy_at_1 = 1'b0;
        for (int n = 0; n < ncyc; n++) begin
            @(negedge clk);
            if (err_valid) begin
                err_cnt++;
                if (err_cyc < 0) begin
                    err_cyc = n; err_c = err_code; busy_at_err = busy;
                end
            end
            if (pkt_valid && val_cyc < 0) begin
                val_cyc = n; val_data = pkt_data;
            end
            if (overrun) begin
                ovr_cnt++; ovr_cyc = n;
            end
            if (n == 1) busy_at_1 = busy;
            p = 1'b0;
            for (int k = 0; k < 12; k++) if (ev[k] == n) p = 1'b1;
            pulse = p;
            pkt_ready = rdy;
        end
        @(negedge clk);
        pulse = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pulse = 1'b0;
            pkt_ready = 1'b1;
        end
    endtask

    task automatic test_reset;
        int bad;
        @(negedge clk); rst = 1'b1; pulse = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({pkt_data, pkt_valid, err_valid, err_code, overrun, busy} !== 15'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {pkt_data, pkt_valid, err_valid, err_code, overrun, busy});
        end
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || err_valid !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL reset_high_pulse_no_edge: got %0d busy cycles expected 0", bad);
        end
        idle(4);
    endtask

    task automatic test_nominal;
        run_seq('{0, 32, 88, 96, 144, 168, -1, -1, -1, -1, -1, -1}, 200, 1'b1);
        tests_run++;
        if (busy_at_1 !== 1'b1) begin
            tests_failed++; $display("FAIL nominal_busy: got %b expected 1", busy_at_1);
        end
        tests_run++;
        if (val_cyc != 191) begin
            tests_failed++; $display("FAIL nominal_valid_cycle: got %0d expected 191", val_cyc);
        end
        tests_run++;
        if (val_data !== 8'hC9) begin
            tests_failed++; $display("FAIL nominal_data: got %h expected c9", val_data);
        end
        tests_run++;
        if (err_cnt != 0 || ovr_cnt != 0) begin
            tests_failed++;
            $display("FAIL nominal_no_err: got err=%0d ovr=%0d expected 0 0", err_cnt, ovr_cnt);
        end
        idle(4);
    endtask

    task automatic test_jitter;
        run_seq('{0, 32, 88, 96, 143, 168, -1, -1, -1, -1, -1, -1}, 200, 1'b1);
        tests_run++;
        if (val_cyc != 191 || val_data !== 8'hC9 || err_cnt != 0) begin
            tests_failed++;
            $display("FAIL jitter_early: got cyc=%0d data=%h err=%0d expected 191 c9 0",
                     val_cyc, val_data, err_cnt);
        end
        idle(4);
        run_seq('{0, 32, 88, 96, 145, 168, -1, -1, -1, -1, -1, -1}, 200, 1'b1);
        tests_run++;
        if (val_cyc != 191 || val_data !== 8'hC9 || err_cnt != 0) begin
            tests_failed++;
            $display("FAIL jitter_late: got cyc=%0d data=%h err=%0d expected 191 c9 0",
                     val_cyc, val_data, err_cnt);
        end
        idle(4);
        run_seq('{0, 32, 88, 96, 146, -1, -1, -1, -1, -1, -1, -1}, 170, 1'b1);
        tests_run++;
        if (err_cyc != 147 || err_c !== 3'd3 || err_cnt != 1) begin
            tests_failed++;
            $display("FAIL jitter_abort: got cyc=%0d code=%0d n=%0d expected 147 3 1",
                     err_cyc, err_c, err_cnt);
        end
        tests_run++;
        if (busy_at_err !== 1'b0 || val_cyc != -1) begin
            tests_failed++;
            $display("FAIL jitter_abort_state: got busy=%b valid_cyc=%0d expected 0 -1",
                     busy_at_err, val_cyc);
        end
        idle(4);
    endtask

    task automatic test_miss_preamble;
        run_seq('{0, 32, 88, 96, -1, -1, -1, -1, -1, -1, -1, -1}, 170, 1'b1);
        tests_run++;
        if (err_cyc != 159 || err_c !== 3'd1) begin
            tests_failed++;
            $display("FAIL miss: got cyc=%0d code=%0d expected 159 1", err_cyc, err_c);
        end
        idle(4);
        run_seq('{0, 40, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1}, 60, 1'b1);
        tests_run++;
        if (err_cyc != 41 || err_c !== 3'd4) begin
            tests_failed++;
            $display("FAIL preamble: got cyc=%0d code=%0d expected 41 4", err_cyc, err_c);
        end
        idle(4);
    endtask

    task automatic test_multi;
        run_seq('{0, 32, 88, 96, 100, -1, -1, -1, -1, -1, -1, -1}, 120, 1'b1);
        tests_run++;
        if (err_cyc != 101 || err_c !== 3'd2) begin
            tests_failed++;
            $display("FAIL multi: got cyc=%0d code=%0d expected 101 2", err_cyc, err_c);
        end
        idle(4);
    endtask

    task automatic test_back_to_back;
        // Second packet starts at 191 with slots 0,1,2,3 -> 8'h1B, gets dropped.
        run_seq('{0, 32, 88, 96, 144, 168, 191, 223, 255, 295, 335, 375}, 400, 1'b0);
        tests_run++;
        if (val_cyc != 191 || val_data !== 8'hC9) begin
            tests_failed++;
            $display("FAIL b2b_first: got cyc=%0d data=%h expected 191 c9", val_cyc, val_data);
        end
        tests_run++;
        if (ovr_cnt != 1 || ovr_cyc != 382) begin
            tests_failed++;
            $display("FAIL b2b_overrun: got n=%0d cyc=%0d expected 1 382", ovr_cnt, ovr_cyc);
        end
        tests_run++;
        if (pkt_valid !== 1'b1 || pkt_data !== 8'hC9) begin
            tests_failed++;
            $display("FAIL b2b_held: got valid=%b data=%h expected 1 c9", pkt_valid, pkt_data);
        end
        pkt_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (pkt_valid !== 1'b0) begin
            tests_failed++; $display("FAIL b2b_accept: got %b expected 0", pkt_valid);
        end
        idle(4);
    endtask

    task automatic test_reset_mid;
        int bad;
        run_seq('{0, 32, 88, 96, 144, 168, -1, -1, -1, -1, -1, -1}, 200, 1'b0);
        run_seq('{0, 32, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1}, 50, 1'b0);
        tests_run++;
        if (busy !== 1'b1 || pkt_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_setup: got busy=%b valid=%b expected 1 1", busy, pkt_valid);
        end
        rst = 1'b1; pulse = 1'b1;
        bad = 0;
        repeat (2) begin
            @(negedge clk);
            if (err_valid !== 1'b0 || overrun !== 1'b0) bad++;
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 5) pulse = 1'b0;
            if (busy !== 1'b0 || pkt_valid !== 1'b0 || err_valid !== 1'b0 || overrun !== 1'b0)
                bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++; $display("FAIL mid_reset_quiet: got %0d bad cycles expected 0", bad);
        end
        tests_run++;
        if (pkt_data !== 8'h00) begin
            tests_failed++; $display("FAIL mid_reset_data: got %h expected 00", pkt_data);
        end
        idle(4);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_jitter();
        test_miss_preamble();
        test_multi();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
